// File: rtl/debounced_step_counter.sv
// Debounced push-button stepper: two-flop synchroniser, press/release filter FSM,
// up/down counter wrapping at a pin-selected limit, and a hex seven-segment readout.
module debounced_step_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    RELEASED       = 2'd0,
    PRESS_FILTER   = 2'd1,
    HELD           = 2'd2,
    RELEASE_FILTER = 2'd3
  } state_t;

  typedef struct packed {
    logic       step;
    logic       dir;
    logic [3:0] limit;
  } step_req_t;

  localparam logic [3:0] FC_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic       clk, rst_n, btn;
  logic       s1, s2;
  state_t     state, state_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       fcnt_hit;
  step_req_t  req;
  logic [6:0] seg;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign btn   = io_in[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // >= rather than == so DEBOUNCE_CYCLES = 1 still resolves on the first filter edge.
  assign fcnt_hit = (fcnt >= FC_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RELEASED;
      fcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    req       = '{step: 1'b0, dir: io_in[3], limit: io_in[7:4]};
    case (state)
      RELEASED: begin
        if (s2) begin
          state_nxt = PRESS_FILTER;
          fcnt_nxt  = 4'd1;
        end
      end
      PRESS_FILTER: begin
        if (!s2) begin
          state_nxt = RELEASED;
          fcnt_nxt  = 4'd0;
        end else if (fcnt_hit) begin
          state_nxt = HELD;
          fcnt_nxt  = 4'd0;
          req.step  = 1'b1;
        end else begin
          fcnt_nxt  = fcnt + 4'd1;
        end
      end
      HELD: begin
        if (!s2) begin
          state_nxt = RELEASE_FILTER;
          fcnt_nxt  = 4'd1;
        end
      end
      RELEASE_FILTER: begin
        if (s2) begin
          state_nxt = HELD;
          fcnt_nxt  = 4'd0;
        end else if (fcnt_hit) begin
          state_nxt = RELEASED;
          fcnt_nxt  = 4'd0;
        end else begin
          fcnt_nxt  = fcnt + 4'd1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        fcnt_nxt  = 4'd0;
      end
    endcase
  end

  // A count left above a lowered limit is only corrected on the next step.
  always_comb begin
    cnt_nxt = cnt;
    if (req.step) begin
      if (!req.dir)
        cnt_nxt = (cnt >= req.limit) ? 4'd0 : cnt + 4'd1;
      else
        cnt_nxt = (cnt == 4'd0 || cnt > req.limit) ? req.limit : cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= 4'd0;
    else        cnt <= cnt_nxt;
  end

  always_comb begin
    seg = 7'h3F;
    case (cnt)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h3F;
    endcase
  end

  assign io_out = {(state == HELD) || (state == RELEASE_FILTER), seg};

endmodule

// File: tb/tb_debounced_step_counter.sv
// Scoreboard bench: stimulus queues each expected io_out change with its cycle,
// a negedge monitor pops and compares whenever io_out changes.
module tb_debounced_step_counter;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  logic       clk, rst_n, btn, dir;
  logic [3:0] limit;
  logic [7:0] io_out;
  logic [7:0] io_in;
  int         cyc;
  int         n_checks, n_pass;
  exp_t       exp_q[$];
  logic [7:0] cur_out, last_out;
  logic [6:0] SEG [16];

  assign io_in = {limit, dir, btn, rst_n, clk};

  debounced_step_counter #(.DEBOUNCE_CYCLES(4)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_out = 'x;
  end

  always @(negedge clk) begin
    if (io_out !== last_out) begin
      exp_t e;
      last_out = io_out;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_change: cycle %0d io_out %h, no change expected", cyc, io_out);
      end else begin
        e = exp_q.pop_front();
        if (e.val === io_out && e.cyc == cyc)
          n_pass++;
        else
          $display("FAIL io_out_change: got %h at cycle %0d, expected %h at cycle %0d",
                   io_out, cyc, e.val, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int c, input logic [7:0] v);
    if (v !== cur_out) begin
      exp_q.push_back('{c, v});
      cur_out = v;
    end
  endtask

  // Called on a negedge: rising btn reaches the step edge 6 cycles later (2 sync + 4 filter).
  task automatic press(input int hi, input int lo, input int exp_cnt);
    int k;
    k = cyc;
    btn = 1'b1;
    expect_at(k + 6, {1'b1, SEG[exp_cnt]});
    tick(hi);
    k = cyc;
    btn = 1'b0;
    expect_at(k + 6, {1'b0, SEG[exp_cnt]});
    tick(lo);
  endtask

  task automatic do_reset();
    int k;
    k = cyc;
    rst_n = 1'b0;
    expect_at(k + 1, 8'h3F);
    tick(1);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    int k;
    SEG = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    cur_out = 'x;
    rst_n = 1'b0;
    btn   = 1'b1;
    dir   = 1'b0;
    limit = 4'h3;

    // Reset held two edges with btn high, then the held button must still filter.
    expect_at(1, 8'h3F);
    tick(2);
    rst_n = 1'b1;
    expect_at(cyc + 6, 8'h86);
    tick(10);
    k = cyc;
    btn = 1'b0;
    expect_at(k + 6, 8'h06);
    tick(10);

    // Reset asserted mid press-filter aborts, then the held button steps afresh.
    k = cyc;
    btn = 1'b1;
    tick(3);
    rst_n = 1'b0;
    expect_at(k + 4, 8'h3F);
    tick(1);
    rst_n = 1'b1;
    expect_at(cyc + 6, 8'h86);
    tick(10);
    k = cyc;
    btn = 1'b0;
    expect_at(k + 6, 8'h06);
    tick(10);

    // Clean presses, limit 3 up.
    do_reset();
    limit = 4'h3;
    dir   = 1'b0;
    press(10, 10, 1);
    press(10, 10, 2);
    press(10, 10, 3);
    press(10, 10, 0);
    press(10, 10, 1);

    // Bounce on press (1,0,1,1,0 then high) and on release (0,1,0,0...).
    k = cyc;
    expect_at(k + 11, {1'b1, SEG[2]});
    btn = 1'b1; tick(1);
    btn = 1'b0; tick(1);
    btn = 1'b1; tick(1);
    btn = 1'b1; tick(1);
    btn = 1'b0; tick(1);
    btn = 1'b1; tick(12);
    k = cyc;
    expect_at(k + 8, {1'b0, SEG[2]});
    btn = 1'b0; tick(1);
    btn = 1'b1; tick(1);
    btn = 1'b0; tick(14);

    // Down count wraps from 0 to limit.
    do_reset();
    limit = 4'h9;
    dir   = 1'b1;
    press(10, 10, 9);
    press(10, 10, 8);
    press(10, 10, 7);

    // Limit lowered below cnt: display holds until the next step.
    limit = 4'h2;
    tick(10);
    dir = 1'b0;
    press(10, 10, 0);
    limit = 4'h9;
    dir   = 1'b1;
    press(10, 10, 9);
    limit = 4'h2;
    tick(5);
    press(10, 10, 2);

    // Limit 0 pins the count at 0 in either direction.
    limit = 4'h0;
    dir   = 1'b0;
    press(8, 8, 0);
    press(8, 8, 0);
    dir = 1'b1;
    press(8, 8, 0);

    // Full hex sweep, wrapping F -> 0.
    limit = 4'hF;
    dir   = 1'b0;
    for (int i = 1; i <= 16; i++) press(8, 8, i % 16);

    tick(10);
    n_checks++;
    if (exp_q.size() == 0)
      n_pass++;
    else
      $display("FAIL missing_changes: %0d expected changes never seen, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
